// File: rtl/hier_fanin_node.sv
// hier_fanin_node: generic N-to-1 fan-in node for the module tree.
// Round-robin arbitration over enabled, valid children, optional packet lock
// (grant held until the granted child's last beat), a one-entry registered
// upstream stage and a saturating count of beats delivered upstream.
module hier_fanin_node #(
   parameter int NUM_CH   = 10,
   parameter int DATA_W   = 32,
   parameter int PKT_MODE = 1,
   parameter int CNT_W    = 16,
   parameter int ID_W     = $clog2(NUM_CH)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          ch_en,
   input  logic [NUM_CH-1:0]          ch_valid,
   input  logic [NUM_CH-1:0]          ch_last,
   input  logic [NUM_CH*DATA_W-1:0]   ch_data,
   output logic [NUM_CH-1:0]          ch_ready,
   output logic                       up_valid,
   output logic [DATA_W-1:0]          up_data,
   output logic [ID_W-1:0]            up_id,
   output logic                       up_last,
   input  logic                       up_ready,
   output logic [CNT_W-1:0]           beat_cnt
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t              state_r;
   logic [ID_W-1:0]     rr_ptr_r;
   logic [ID_W-1:0]     lock_id_r;

   logic [NUM_CH-1:0]   elig_s;
   logic [ID_W-1:0]     rr_idx_s;
   logic                rr_found_s;
   logic [ID_W-1:0]     grant_s;
   logic                grant_valid_s;
   logic                out_free_s;
   logic                accept_s;
   logic [DATA_W-1:0]   data_sel_s;
   logic                last_raw_s;
   logic                last_sel_s;

   assign elig_s     = ch_valid & ch_en;
   // The output register can take a new beat when empty or draining this cycle.
   assign out_free_s = ~up_valid | up_ready;
   assign accept_s   = grant_valid_s & out_free_s;
   // Without packet mode every beat closes its own packet.
   assign last_sel_s = (PKT_MODE != 0) ? last_raw_s : 1'b1;

   // Round-robin search: first eligible index after rr_ptr, wrapping at NUM_CH-1.
   always_comb begin : rr_search
      logic [ID_W:0]   sum_v;
      logic [ID_W-1:0] cand_v;
      rr_found_s = 1'b0;
      rr_idx_s   = '0;
      sum_v      = '0;
      cand_v     = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         sum_v  = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
         cand_v = (sum_v >= (ID_W+1)'(NUM_CH)) ? ID_W'(sum_v - (ID_W+1)'(NUM_CH))
                                               : sum_v[ID_W-1:0];
         if (!rr_found_s && elig_s[cand_v]) begin
            rr_found_s = 1'b1;
            rr_idx_s   = cand_v;
         end else begin
            rr_found_s = rr_found_s;
         end
      end
   end

   // Grant selection: locked channel ignores its enable so packets are never cut.
   always_comb begin
      if ((PKT_MODE != 0) && (state_r == ST_LOCKED)) begin
         grant_s       = lock_id_r;
         grant_valid_s = ch_valid[lock_id_r];
      end else begin
         grant_s       = rr_idx_s;
         grant_valid_s = rr_found_s;
      end
   end

   // Payload/last mux driven only by the grant index (no data-to-control path).
   always_comb begin
      data_sel_s = '0;
      last_raw_s = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_s == ID_W'(i)) begin
            data_sel_s = ch_data[i*DATA_W +: DATA_W];
            last_raw_s = ch_last[i];
         end else begin
            last_raw_s = last_raw_s;
         end
      end
   end

   // One-hot ready toward the granted child; held low while in reset.
   always_comb begin
      ch_ready = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_ready[i] = rst_n & accept_s & (grant_s == ID_W'(i));
      end
   end

   // Arbitration FSM: lock on a non-last beat, release on the locked channel's last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         lock_id_r <= '0;
         rr_ptr_r  <= ID_W'(NUM_CH - 1);
      end else if (accept_s) begin
         case (state_r)
            ST_IDLE: begin
               rr_ptr_r <= grant_s;
               if ((PKT_MODE != 0) && !last_sel_s) begin
                  state_r   <= ST_LOCKED;
                  lock_id_r <= grant_s;
               end
            end
            ST_LOCKED: begin
               if (last_sel_s) begin
                  state_r  <= ST_IDLE;
                  rr_ptr_r <= grant_s;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Upstream one-entry register: load on accept, clear when drained without refill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_valid <= 1'b0;
         up_data  <= '0;
         up_id    <= '0;
         up_last  <= 1'b0;
      end else if (accept_s) begin
         up_valid <= 1'b1;
         up_data  <= data_sel_s;
         up_id    <= grant_s;
         up_last  <= last_sel_s;
      end else if (up_valid && up_ready) begin
         up_valid <= 1'b0;
      end
   end

   // Saturating count of beats taken by the upstream side.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
      end else if (up_valid && up_ready && (beat_cnt != {CNT_W{1'b1}})) begin
         beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hier_fanin_node.sv
// Bench for hier_fanin_node: two instances share the child-side stimulus,
// one per-beat (PKT_MODE=0, 16-bit counter) and one packet-locking with a
// 4-bit counter. A transaction-level model predicts ready, outputs and counts;
// a scoreboard tracks beats of the per-beat instance end to end.
module tb_hier_fanin_node;

   localparam int N  = 10;
   localparam int DW = 32;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      ch_en;
   logic [N-1:0]      ch_valid;
   logic [N-1:0]      ch_last;
   logic [N*DW-1:0]   ch_data;
   logic              up_ready;
   logic [DW-1:0]     chd [N];

   logic [N-1:0]      rdy_a, rdy_b;
   logic              uv_a, uv_b, ul_a, ul_b;
   logic [DW-1:0]     ud_a, ud_b;
   logic [3:0]        uid_a, uid_b;
   logic [15:0]       cnt_a;
   logic [3:0]        cnt_b;

   logic [N-1:0]      rdy_a_smp, rdy_b_smp;
   int                n_checks = 0;
   int                n_pass   = 0;

   hier_fanin_node #(.NUM_CH(N), .DATA_W(DW), .PKT_MODE(0), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_valid(ch_valid), .ch_last(ch_last),
      .ch_data(ch_data), .ch_ready(rdy_a), .up_valid(uv_a), .up_data(ud_a), .up_id(uid_a),
      .up_last(ul_a), .up_ready(up_ready), .beat_cnt(cnt_a));

   hier_fanin_node #(.NUM_CH(N), .DATA_W(DW), .PKT_MODE(1), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_valid(ch_valid), .ch_last(ch_last),
      .ch_data(ch_data), .ch_ready(rdy_b), .up_valid(uv_b), .up_data(ud_b), .up_id(uid_b),
      .up_last(ul_b), .up_ready(up_ready), .beat_cnt(cnt_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack per-channel payloads onto the flat bus.
   always_comb begin
      for (int i = 0; i < N; i++) ch_data[i*DW +: DW] = chd[i];
   end

   // ---------------- reference model ----------------
   typedef struct {
      bit            locked;
      int            lock_id;
      int            ptr;
      bit            ov;
      logic [DW-1:0] od;
      int            oid;
      bit            ol;
      int            cnt;
   } mdl_t;

   typedef struct {
      int            id;
      logic [DW-1:0] d;
   } beat_t;

   mdl_t  ma, mb;
   beat_t sb [$];

   function automatic mdl_t m_reset();
      mdl_t m;
      m.locked = 1'b0; m.lock_id = 0; m.ptr = N - 1;
      m.ov = 1'b0; m.od = '0; m.oid = 0; m.ol = 1'b0; m.cnt = 0;
      return m;
   endfunction

   // Which child would win this cycle (ignoring output backpressure), -1 if none.
   function automatic int m_grant(mdl_t m, bit pkt);
      if (pkt && m.locked) return ch_valid[m.lock_id] ? m.lock_id : -1;
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (m.ptr + k) % N;
         if (ch_valid[i] && ch_en[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] m_ready(mdl_t m, bit pkt);
      logic [N-1:0] r;
      int g;
      r = '0;
      g = m_grant(m, pkt);
      if (rst_n && g >= 0 && (!m.ov || up_ready)) r[g] = 1'b1;
      return r;
   endfunction

   function automatic mdl_t m_step(mdl_t m, bit pkt, int cmax);
      mdl_t n;
      int   g;
      bit   lst;
      n = m;
      g = m_grant(m, pkt);
      if (m.ov && up_ready) begin
         n.ov = 1'b0;
         if (m.cnt < cmax) n.cnt = m.cnt + 1;
      end
      if (g >= 0 && (!m.ov || up_ready)) begin
         lst = pkt ? ch_last[g] : 1'b1;
         n.ov = 1'b1; n.od = chd[g]; n.oid = g; n.ol = lst;
         if (!m.locked) begin
            n.ptr = g;
            if (!lst) begin n.locked = 1'b1; n.lock_id = g; end
         end else if (lst) begin
            n.locked = 1'b0;
            n.ptr    = g;
         end
      end
      return n;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic rand_data();
      for (int i = 0; i < N; i++) chd[i] = $urandom;
   endtask

   // One clock: check ready before the edge, advance model at the edge, check outputs after.
   task automatic cycle();
      int    g;
      beat_t b;
      #1;
      rdy_a_smp = rdy_a;
      rdy_b_smp = rdy_b;
      chk("ready_a", 64'(rdy_a), 64'(m_ready(ma, 1'b0)));
      chk("ready_b", 64'(rdy_b), 64'(m_ready(mb, 1'b1)));
      if (rst_n && uv_a && up_ready) begin
         chk("sb_depth", 64'(sb.size()), 64'd1);
         if (sb.size() > 0) begin
            b = sb.pop_front();
            chk("sb_id", 64'(uid_a), 64'(b.id));
            chk("sb_data", 64'(ud_a), 64'(b.d));
         end
      end
      @(posedge clk);
      if (rst_n) begin
         g = m_grant(ma, 1'b0);
         if (g >= 0 && (!ma.ov || up_ready)) sb.push_back('{g, chd[g]});
         ma = m_step(ma, 1'b0, 65535);
         mb = m_step(mb, 1'b1, 15);
      end else begin
         ma = m_reset();
         mb = m_reset();
         sb.delete();
      end
      @(negedge clk);
      chk("up_valid_a", 64'(uv_a), 64'(ma.ov));
      chk("up_data_a", 64'(ud_a), 64'(ma.od));
      chk("up_id_a", 64'(uid_a), 64'(ma.oid));
      chk("up_last_a", 64'(ul_a), 64'(ma.ol));
      chk("beat_cnt_a", 64'(cnt_a), 64'(ma.cnt));
      chk("up_valid_b", 64'(uv_b), 64'(mb.ov));
      chk("up_data_b", 64'(ud_b), 64'(mb.od));
      chk("up_id_b", 64'(uid_b), 64'(mb.oid));
      chk("up_last_b", 64'(ul_b), 64'(mb.ol));
      chk("beat_cnt_b", 64'(cnt_b), 64'(mb.cnt));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) cycle();
      rst_n = 1'b1;
   endtask

   int ids [$];
   int lasts [$];
   int beats;

   initial begin
      rst_n    = 1'b1;
      ch_en    = '1;
      ch_valid = '1;
      ch_last  = '1;
      up_ready = 1'b1;
      rand_data();
      ma = m_reset();
      mb = m_reset();
      @(negedge clk);

      // Reset held 3 cycles with every child valid.
      rst_n = 1'b0;
      repeat (3) begin
         rand_data();
         cycle();
         chk("rst_ready_a", 64'(rdy_a_smp), 64'd0);
         chk("rst_ready_b", 64'(rdy_b_smp), 64'd0);
      end
      rst_n = 1'b1;
      rand_data();
      cycle();
      chk("first_grant", 64'(rdy_a_smp), 64'd1);
      chk("first_id", 64'(uid_a), 64'd0);
      chk("first_valid", 64'(uv_a), 64'd1);

      // Round-robin fairness and counter saturation.
      do_reset();
      ch_valid = '1; ch_en = '1; ch_last = '1; up_ready = 1'b1;
      ids.delete();
      repeat (21) begin
         rand_data();
         cycle();
         if (uv_a) ids.push_back(int'(uid_a));
      end
      chk("rr_len", 64'(ids.size()), 64'd21);
      for (int j = 0; j < 20 && j < ids.size(); j++) chk("rr_seq", 64'(ids[j]), 64'(j % 10));
      chk("rr_cnt", 64'(cnt_a), 64'd20);
      chk("sat_cnt", 64'(cnt_b), 64'd15);

      // Sparse valid with channel 7 masked, then unmasked.
      do_reset();
      ch_valid = 10'b00_1000_1000;
      ch_en    = 10'b11_0111_1111;
      ids.delete();
      repeat (6) begin
         rand_data();
         cycle();
         if (uv_a) ids.push_back(int'(uid_a));
      end
      chk("mask_len", 64'(ids.size()), 64'd6);
      foreach (ids[j]) chk("mask_only3", 64'(ids[j]), 64'd3);
      ch_en = '1;
      ids.delete();
      repeat (8) begin
         rand_data();
         cycle();
         if (uv_a) ids.push_back(int'(uid_a));
      end
      chk("alt_len", 64'(ids.size()), 64'd8);
      foreach (ids[j]) chk("alt_seq", 64'(ids[j]), (j % 2 == 0) ? 64'd7 : 64'd3);

      // Packet lock: ch2 sends 4 beats while ch5 stays valid.
      do_reset();
      ch_en = '1; ch_last = '1; ch_valid = 10'b00_0010_0100;
      beats = 0;
      ids.delete(); lasts.delete();
      repeat (5) begin
         ch_valid[2] = (beats < 4);
         ch_last[2]  = (beats == 3);
         rand_data();
         cycle();
         if (rdy_b_smp[2]) beats++;
         if (uv_b) begin ids.push_back(int'(uid_b)); lasts.push_back(int'(ul_b)); end
      end
      chk("pkt_len", 64'(ids.size()), 64'd5);
      for (int j = 0; j < 5 && j < ids.size(); j++) begin
         chk("pkt_id", 64'(ids[j]), (j < 4) ? 64'd2 : 64'd5);
         chk("pkt_last", 64'(lasts[j]), (j >= 3) ? 64'd1 : 64'd0);
      end

      // Reset in the middle of a locked packet.
      do_reset();
      ch_valid = 10'b00_0010_0100;
      ch_last  = 10'b11_1111_1011;
      repeat (2) begin rand_data(); cycle(); end
      rst_n = 1'b0;
      cycle();
      chk("midrst_ready_b", 64'(rdy_b_smp), 64'd0);
      rst_n    = 1'b1;
      ch_valid = 10'b00_0010_0001;
      ch_last  = '1;
      rand_data();
      cycle();
      chk("midrst_regrant_b", 64'(rdy_b_smp), 64'd1);
      chk("midrst_regrant_a", 64'(rdy_a_smp), 64'd1);

      // Backpressure: 5 stalled cycles, then release.
      do_reset();
      ch_valid = '1; ch_en = '1; up_ready = 1'b1;
      repeat (3) begin rand_data(); cycle(); end
      up_ready = 1'b0;
      repeat (5) begin
         ch_valid = N'($urandom);
         rand_data();
         cycle();
         chk("bp_ready_a", 64'(rdy_a_smp), 64'd0);
         chk("bp_ready_b", 64'(rdy_b_smp), 64'd0);
         chk("bp_valid_a", 64'(uv_a), 64'd1);
      end
      up_ready = 1'b1;
      repeat (10) begin
         ch_valid = N'($urandom);
         rand_data();
         cycle();
      end

      // Randomized traffic, enables, packet boundaries and backpressure.
      repeat (600) begin
         ch_valid = N'($urandom);
         ch_en    = N'($urandom) | N'($urandom);
         ch_last  = N'($urandom) | N'($urandom);
         up_ready = ($urandom_range(0, 3) != 0);
         rand_data();
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/hier_fanin_node.md
# hier_fanin_node

Parametrised N-to-1 fan-in node for the hierarchical module tree. It merges NUM_CH child channels into one upstream channel using round-robin arbitration, valid/ready handshakes and a registered output stage. An optional packet mode locks the grant until the granted child's last beat. It replaces fixed-width, fixed-count child lists with one generic node that can be instantiated at any tree level.

## Interface
Parameters:
- NUM_CH, 10, number of child channels (2..64; need not be a power of two)
- DATA_W, 32, payload width per beat
- PKT_MODE, 1, 1 = grant held until `ch_last` beat accepted; 0 = re-arbitrate every beat
- CNT_W, 16, width of saturating accepted-beat counter
- ID_W, $clog2(NUM_CH), derived; not to be overridden

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ch_en  in  NUM_CH  per-channel enable mask; disabled channels are never granted
- ch_valid  in  NUM_CH  child beat valid
- ch_last  in  NUM_CH  child beat is last of packet; ignored when PKT_MODE=0
- ch_data  in  NUM_CH*DATA_W  child payloads, channel i at [i*DATA_W +: DATA_W]
- ch_ready  out  NUM_CH  child beat accepted when ch_valid[i] & ch_ready[i]
- up_valid  out  1  upstream beat valid (registered)
- up_data  out  DATA_W  upstream payload (registered)
- up_id  out  ID_W  source channel index of up_data
- up_last  out  1  end of packet; forced 1 when PKT_MODE=0
- up_ready  in  1  upstream accepts beat
- beat_cnt  out  CNT_W  saturating count of accepted upstream beats

## Operation
- Eligibility: `elig[i] = ch_valid[i] & ch_en[i]`.
- Round-robin pointer `rr_ptr` holds the last granted index. Search starts at `rr_ptr+1` and wraps at NUM_CH-1 to 0. The first eligible index wins.
- FSM states:
  - IDLE: no lock. The grant is the combinational RR winner.
  - LOCKED (PKT_MODE=1 only): the grant is fixed to `lock_id`.
- Transitions:
  - IDLE -> LOCKED on an accepted beat with `ch_last=0`; `lock_id` takes the granted index.
  - LOCKED -> IDLE on an accepted beat from `lock_id` with `ch_last=1`.
  - A single-beat packet (`last=1` on the first beat) stays in IDLE.
- `rr_ptr` updates to the granted index on every accepted beat in IDLE. In LOCKED it updates on the closing beat.
- `ch_ready[i] = grant_valid & (grant==i) & (!up_valid | up_ready)`. At most one bit is set at any time.
- Output stage: a one-entry register.
  - On accept: load data, id and last; set `up_valid`.
  - On `up_valid & up_ready` with no new accept: clear `up_valid`.
  - Data, id and last hold their value while `up_valid & !up_ready`.
- A channel with `ch_en` deasserted while in LOCKED on that channel stays granted until its last beat. Disabling never truncates a packet.
- `beat_cnt` increments on each `up_valid & up_ready` and saturates at 2^CNT_W-1. It does not wrap.

## Timing
- Reset (asynchronous assert, synchronous release via the clock edge):
  - `up_valid=0`, `up_data=0`, `up_id=0`, `up_last=0`, `beat_cnt=0`
  - FSM=IDLE, `rr_ptr=NUM_CH-1` (so channel 0 has first priority)
  - `ch_ready` is all zeros during reset.
- Latency: a beat accepted on edge k appears on `up_*` in the cycle after edge k, i.e. 1 cycle.
- Throughput: 1 beat/cycle when `up_ready=1` continuously. Simultaneous drain and accept in one cycle is required and gives no bubble.
- Backpressure: `up_ready=0` with `up_valid=1` forces `ch_ready=0` for all channels in that cycle.
- `ch_ready` is combinational from `ch_valid`, `ch_en`, FSM, `rr_ptr`, `up_valid` and `up_ready`. There is no combinational path from `ch_data` to any output.
- Reset asserted mid-packet: the lock is dropped, the output beat is discarded, and no partial-packet recovery is performed.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with all ch_valid=1 -> all outputs 0, ch_ready=0. After release, the first grant is channel 0 and up_id=0 one cycle later.
- RR fairness, PKT_MODE=0, NUM_CH=10, all ch_valid=1, ch_en=all ones, up_ready=1 -> up_id sequence 0,1,…,9,0,…; wrap 9->0 with no bubble; beat_cnt=20 after 20 beats.
- Mask/sparse: ch_valid only on 3 and 7, ch_en[7]=0 -> only id 3 is granted. Setting ch_en[7]=1 -> ids alternate 3,7,3,7.
- Packet lock, PKT_MODE=1: ch2 sends 4 beats (last on beat 4) while ch5 is valid throughout -> up_id=2 for 4 consecutive beats with up_last on the 4th, then up_id=5.
- Backpressure: up_ready=0 for 5 cycles with up_valid=1 -> up_data/up_id stable and ch_ready=0. Releasing up_ready -> no beat is lost or duplicated (scoreboard by id and payload).
- Saturation, CNT_W=4: 20 accepted beats -> beat_cnt holds at 15. Asserting rst_n=0 mid-packet -> FSM returns to IDLE and the next grant starts from channel 0.
